// File: rtl/uart_pkg.sv
// uart_pkg: frame state encoding shared by the UART transmit and receive paths
package uart_pkg;
   typedef enum logic [2:0] {UART_IDLE, UART_START, UART_DATA, UART_PARITY, UART_STOP} uart_state;
endpackage

// File: rtl/uart_tx_parity.sv
// parity: odd-parity bit of a data word
module parity #(
   parameter int BITS = 8
) (
   input  logic [BITS-1:0] data,
   output logic            odd
);
   assign odd = ~^data;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART/UPDI frame serializer, one frame bit per clk, with half-duplex drive enable
module uart_tx
   import uart_pkg::*;
#(
   parameter int    DATA_BITS  = 8,
   parameter string PARITY_BIT = "none",
   parameter int    STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_data_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_en,
   output logic                 tx_done
);
   localparam int W = $clog2(DATA_BITS + 1);
   localparam bit PAR_EN = PARITY_BIT != "none";
   localparam bit PAR_EVEN = PARITY_BIT == "even";
   if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       !(PARITY_BIT == "none" || PARITY_BIT == "even" || PARITY_BIT == "odd")) begin : g_bad_param
      $error("uart_tx: unsupported DATA_BITS/PARITY_BIT/STOP_BITS");
   end
   uart_state state, state_n;
   logic [W-1:0] cnt, cnt_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic par, par_n, odd, last_stop, hs, tx_n;
   parity #(.BITS(DATA_BITS)) u_parity (.data(tx_data), .odd(odd));
   assign last_stop = state == UART_STOP && cnt == W'(STOP_BITS - 1);
   assign tx_ready = !rst && (state == UART_IDLE || last_stop);
   assign hs = tx_data_valid && tx_ready;
   // tx is registered from the state being entered, so the start bit appears right at the handshake edge
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      sh_n = hs ? tx_data : sh;
      par_n = hs ? (PAR_EVEN ? ~odd : odd) : par;
      case (state)
         UART_IDLE: state_n = hs ? UART_START : UART_IDLE;
         UART_START: begin
            state_n = UART_DATA;
            cnt_n = '0;
         end
         UART_DATA:
            if (cnt == W'(DATA_BITS - 1)) begin
               state_n = PAR_EN ? UART_PARITY : UART_STOP;
               cnt_n = '0;
            end else begin
               cnt_n = cnt + W'(1);
               sh_n = sh >> 1;
            end
         UART_PARITY: begin
            state_n = UART_STOP;
            cnt_n = '0;
         end
         UART_STOP:
            if (last_stop) begin
               state_n = hs ? UART_START : UART_IDLE;
               cnt_n = '0;
            end else begin
               cnt_n = cnt + W'(1);
            end
         default: state_n = UART_IDLE;
      endcase
      tx_n = state_n == UART_DATA ? sh_n[0] : state_n == UART_PARITY ? par : state_n != UART_START;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= UART_IDLE;
         cnt <= '0;
         tx <= 1'b1;
         tx_en <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         sh <= sh_n;
         par <= par_n;
         tx <= tx_n;
         tx_en <= state_n != UART_IDLE;
         tx_done <= last_stop;
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx in 8N1, 8E2, 8O1 and 8E1 configurations
module tb_uart_tx;
   logic clk = 1'b0;
   logic rst;
   logic [7:0] d [4];
   logic [3:0] v, rdy, tx, en, done;
   int n_assert = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   uart_tx #(.DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .tx_data(d[0]), .tx_data_valid(v[0]), .tx_ready(rdy[0]),
      .tx(tx[0]), .tx_en(en[0]), .tx_done(done[0]));
   uart_tx #(.DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(2)) u_8e2 (
      .clk(clk), .rst(rst), .tx_data(d[1]), .tx_data_valid(v[1]), .tx_ready(rdy[1]),
      .tx(tx[1]), .tx_en(en[1]), .tx_done(done[1]));
   uart_tx #(.DATA_BITS(8), .PARITY_BIT("odd"), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst(rst), .tx_data(d[2]), .tx_data_valid(v[2]), .tx_ready(rdy[2]),
      .tx(tx[2]), .tx_en(en[2]), .tx_done(done[2]));
   uart_tx #(.DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .tx_data(d[3]), .tx_data_valid(v[3]), .tx_ready(rdy[3]),
      .tx(tx[3]), .tx_en(en[3]), .tx_done(done[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // frame bit i is frame[i]; the word on d[k] is replaced by 'later' right after the handshake
   task automatic send(input int k, input logic [7:0] data, input logic [7:0] later,
                       input logic [15:0] frame, input int f);
      d[k] = data;
      v[k] = 1'b1;
      chk("ready_before", rdy[k], 1);
      @(negedge clk);
      v[k] = 1'b0;
      d[k] = later;
      for (int i = 0; i < f; i++) begin
         chk("tx_bit", tx[k], frame[i]);
         chk("tx_en_frame", en[k], 1);
         chk("tx_done_low", done[k], 0);
         @(negedge clk);
      end
      chk("tx_done_pulse", done[k], 1);
      chk("tx_idle", tx[k], 1);
      chk("tx_en_idle", en[k], 0);
      chk("ready_after", rdy[k], 1);
      @(negedge clk);
      chk("tx_done_end", done[k], 0);
   endtask

   initial begin
      logic [23:0] bb;
      rst = 1'b1;
      v = '0;
      for (int k = 0; k < 4; k++) d[k] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_tx", tx, 4'hF);
      chk("rst_en", en, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", rdy, 0);
      rst = 1'b0;
      #1;
      chk("ready_out_of_rst", rdy, 4'hF);
      @(negedge clk);
      send(0, 8'hA3, 8'hFF, {6'b0, 1'b1, 8'hA3, 1'b0}, 10);
      send(1, 8'h55, 8'h55, {4'b0, 2'b11, 1'b0, 8'h55, 1'b0}, 12);
      send(2, 8'h07, 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      send(3, 8'h07, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      bb = {2'b11, 1'b0, 8'hA3, 1'b0, 2'b11, 1'b0, 8'h55, 1'b0};
      d[1] = 8'h55;
      v[1] = 1'b1;
      @(negedge clk);
      d[1] = 8'hA3;
      for (int i = 0; i < 24; i++) begin
         chk("b2b_tx", tx[1], bb[i]);
         chk("b2b_en", en[1], 1);
         chk("b2b_done", done[1], i == 12);
         if (i == 11) chk("b2b_ready_last_stop", rdy[1], 1);
         if (i == 12) v[1] = 1'b0;
         @(negedge clk);
      end
      chk("b2b_done_second", done[1], 1);
      chk("b2b_tx_idle", tx[1], 1);
      chk("b2b_en_idle", en[1], 0);
      @(negedge clk);
      d[0] = 8'hA3;
      v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_bit3", tx[0], 0);
      chk("abort_en_before", en[0], 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", tx[0], 1);
      chk("abort_en", en[0], 0);
      chk("abort_done", done[0], 0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("abort_no_done", done[0], 0);
         chk("abort_line_idle", tx[0], 1);
         @(negedge clk);
      end
      send(0, 8'h5A, 8'h5A, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
